// File: rtl/nor_bus_master_if.sv
// Command, response and NOR pin-side signals of the NOR bus sequencer.
// The master modport is the sequencer; the slave modport is the command source and top level.
interface nor_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [22:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        nor_vcc;
  logic [15:0] nor_d_in;
  logic        bus_own;
  logic        bus_drive;
  logic        d_drive;
  logic [22:0] out_a;
  logic [15:0] out_d;
  logic        out_ce;
  logic        out_oe;
  logic        out_we;
  logic        out_reset;
  logic        vcc_lost;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, nor_vcc, nor_d_in,
    output cmd_ready, rsp_valid, rsp_data, bus_own, bus_drive, d_drive,
    output out_a, out_d, out_ce, out_oe, out_we, out_reset, vcc_lost
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, nor_vcc, nor_d_in,
    input  cmd_ready, rsp_valid, rsp_data, bus_own, bus_drive, d_drive,
    input  out_a, out_d, out_ce, out_oe, out_we, out_reset, vcc_lost
  );
endinterface

// File: rtl/nor_bus_master.sv
// Takes the PS3 NOR bus from the console and runs single-word read, write and reset-pulse
// commands with programmable timing; all outputs except cmd_ready are registered.
module nor_bus_master #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned PULSE_CYC  = 6,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned RESET_CYC  = 250
) (
  input logic              mclk_i,
  input logic              reset_ni,
  nor_bus_master_if.master bus
);
  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StTakeover = 3'd1;
  localparam logic [2:0] StOwned    = 3'd2;
  localparam logic [2:0] StSetup    = 3'd3;
  localparam logic [2:0] StPulse    = 3'd4;
  localparam logic [2:0] StHold     = 3'd5;
  localparam logic [2:0] StRstp     = 3'd6;
  localparam logic [2:0] StRelease  = 3'd7;

  localparam logic [1:0] OpRead    = 2'b00;
  localparam logic [1:0] OpWrite   = 2'b01;
  localparam logic [1:0] OpRstp    = 2'b10;
  localparam logic [1:0] OpRelease = 2'b11;

  // Counters are loaded with N-1 and the phase ends when they reach zero.
  localparam logic [15:0] SettleLd = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] SetupLd  = 16'(SETUP_CYC - 1);
  localparam logic [15:0] PulseLd  = 16'(PULSE_CYC - 1);
  localparam logic [15:0] HoldLd   = 16'(HOLD_CYC - 1);
  localparam logic [15:0] ResetLd  = 16'(RESET_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] rd_q, rd_d;
  logic        bus_own_q, bus_own_d, bus_drive_q, bus_drive_d, d_drive_q, d_drive_d;
  logic [22:0] out_a_q, out_a_d;
  logic [15:0] out_d_q, out_d_d;
  logic        out_ce_q, out_ce_d, out_oe_q, out_oe_d, out_we_q, out_we_d;
  logic        out_reset_q, out_reset_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        vcc_lost_q, vcc_lost_d;
  logic        cmd_ready, accept, cnt_done;

  assign cmd_ready = bus.nor_vcc && (state_q == StIdle || state_q == StOwned);
  assign accept    = bus.cmd_valid && cmd_ready;
  assign cnt_done  = (cnt_q == 16'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_done ? cnt_q : cnt_q - 16'd1;
    op_d        = op_q;
    rd_d        = rd_q;
    bus_own_d   = bus_own_q;
    bus_drive_d = bus_drive_q;
    d_drive_d   = d_drive_q;
    out_a_d     = out_a_q;
    out_d_d     = out_d_q;
    out_ce_d    = out_ce_q;
    out_oe_d    = out_oe_q;
    out_we_d    = out_we_q;
    out_reset_d = out_reset_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    vcc_lost_d  = accept ? 1'b0 : vcc_lost_q;

    unique case (state_q)
      StIdle: begin
        if (accept && bus.cmd_op != OpRelease) begin
          state_d   = StTakeover;
          cnt_d     = SettleLd;
          bus_own_d = 1'b1;
          op_d      = bus.cmd_op;
          out_a_d   = bus.cmd_addr;
          out_d_d   = bus.cmd_wdata;
        end
      end
      StTakeover: begin
        if (cnt_done) begin
          bus_drive_d = 1'b1;
          if (op_q == OpRstp) begin
            state_d     = StRstp;
            cnt_d       = ResetLd;
            out_reset_d = 1'b1;
          end else begin
            state_d   = StSetup;
            cnt_d     = SetupLd;
            out_ce_d  = 1'b1;
            d_drive_d = (op_q == OpWrite);
          end
        end
      end
      StOwned: begin
        if (accept) begin
          op_d = bus.cmd_op;
          unique case (bus.cmd_op)
            OpRead, OpWrite: begin
              state_d   = StSetup;
              cnt_d     = SetupLd;
              out_a_d   = bus.cmd_addr;
              out_d_d   = bus.cmd_wdata;
              out_ce_d  = 1'b1;
              d_drive_d = (bus.cmd_op == OpWrite);
            end
            OpRstp: begin
              state_d     = StRstp;
              cnt_d       = ResetLd;
              out_reset_d = 1'b1;
            end
            default: begin
              state_d     = StRelease;
              cnt_d       = SettleLd;
              bus_drive_d = 1'b0;
              d_drive_d   = 1'b0;
            end
          endcase
        end
      end
      StSetup: begin
        if (cnt_done) begin
          state_d  = StPulse;
          cnt_d    = PulseLd;
          out_oe_d = (op_q == OpRead);
          out_we_d = (op_q == OpWrite);
        end
      end
      StPulse: begin
        if (cnt_done) begin
          state_d  = StHold;
          cnt_d    = HoldLd;
          out_oe_d = 1'b0;
          out_we_d = 1'b0;
          if (op_q == OpRead) rd_d = bus.nor_d_in;
        end
      end
      StHold: begin
        if (cnt_done) begin
          state_d   = StOwned;
          out_ce_d  = 1'b0;
          d_drive_d = 1'b0;
          if (op_q == OpRead) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_q;
          end
        end
      end
      StRstp: begin
        if (cnt_done) begin
          state_d     = StOwned;
          out_reset_d = 1'b0;
        end
      end
      StRelease: begin
        if (cnt_done) begin
          state_d   = StIdle;
          bus_own_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Power loss abandons the bus at once; only a command in flight is flagged.
    if (!bus.nor_vcc && state_q != StIdle) begin
      state_d     = StIdle;
      cnt_d       = 16'd0;
      op_d        = OpRead;
      rd_d        = 16'd0;
      bus_own_d   = 1'b0;
      bus_drive_d = 1'b0;
      d_drive_d   = 1'b0;
      out_a_d     = 23'd0;
      out_d_d     = 16'd0;
      out_ce_d    = 1'b0;
      out_oe_d    = 1'b0;
      out_we_d    = 1'b0;
      out_reset_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = 16'd0;
      vcc_lost_d  = vcc_lost_q || !(state_q == StOwned || state_q == StRelease);
    end
  end

  always_ff @(posedge mclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      op_q        <= OpRead;
      rd_q        <= 16'd0;
      bus_own_q   <= 1'b0;
      bus_drive_q <= 1'b0;
      d_drive_q   <= 1'b0;
      out_a_q     <= 23'd0;
      out_d_q     <= 16'd0;
      out_ce_q    <= 1'b0;
      out_oe_q    <= 1'b0;
      out_we_q    <= 1'b0;
      out_reset_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'd0;
      vcc_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      bus_own_q   <= bus_own_d;
      bus_drive_q <= bus_drive_d;
      d_drive_q   <= d_drive_d;
      out_a_q     <= out_a_d;
      out_d_q     <= out_d_d;
      out_ce_q    <= out_ce_d;
      out_oe_q    <= out_oe_d;
      out_we_q    <= out_we_d;
      out_reset_q <= out_reset_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      vcc_lost_q  <= vcc_lost_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.bus_own   = bus_own_q;
  assign bus.bus_drive = bus_drive_q;
  assign bus.d_drive   = d_drive_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_d     = out_d_q;
  assign bus.out_ce    = out_ce_q;
  assign bus.out_oe    = out_oe_q;
  assign bus.out_we    = out_we_q;
  assign bus.out_reset = out_reset_q;
  assign bus.vcc_lost  = vcc_lost_q;
endmodule

// File: tb/tb_nor_bus_master.sv
// Directed bench for nor_bus_master with default timing parameters.
module tb_nor_bus_master;
  logic mclk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  nor_bus_master_if bus_if ();

  nor_bus_master dut (
    .mclk_i   (mclk),
    .reset_ni (reset_n),
    .bus      (bus_if)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Offers one command for a single cycle (cycle 0); returns at the cycle 1 sample point.
  task automatic issue(input string tag, input logic [1:0] op, input logic [22:0] a,
                       input logic [15:0] d);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_addr  = a;
    bus_if.cmd_wdata = d;
    #1;
    check_eq({tag, "_rdy"}, bus_if.cmd_ready, 1'b1);
    @(negedge mclk);
    bus_if.cmd_valid = 1'b0;
  endtask

  // Read or write with offset o (0 from OWNED, 4 from IDLE); records cycles 1..16 as bit vectors.
  task automatic run_access(input string tag, input bit wr, input logic [22:0] a,
                            input logic [15:0] d, input int o);
    logic [31:0] own, drv, dd, ce, oe, we, rv, rdy;
    logic [31:0] e_own, e_drv, e_dd, e_ce, e_oe, e_we, e_rv, e_rdy;
    own = '0; drv = '0; dd = '0; ce = '0; oe = '0; we = '0; rv = '0; rdy = '0;
    e_own = '0; e_drv = '0; e_dd = '0; e_ce = '0; e_oe = '0; e_we = '0; e_rv = '0; e_rdy = '0;
    issue(tag, wr ? 2'b01 : 2'b00, a, d);
    for (int c = 1; c <= 16; c++) begin
      own[c] = bus_if.bus_own;   drv[c] = bus_if.bus_drive; dd[c] = bus_if.d_drive;
      ce[c]  = bus_if.out_ce;    oe[c]  = bus_if.out_oe;    we[c] = bus_if.out_we;
      rv[c]  = bus_if.rsp_valid; rdy[c] = bus_if.cmd_ready;
      e_own[c] = 1'b1;
      e_drv[c] = (c >= 1 + o);
      e_ce[c]  = (c >= 1 + o) && (c <= 10 + o);
      e_dd[c]  = wr && e_ce[c];
      e_oe[c]  = !wr && (c >= 3 + o) && (c <= 8 + o);
      e_we[c]  = wr && (c >= 3 + o) && (c <= 8 + o);
      e_rv[c]  = !wr && (c == 11 + o);
      e_rdy[c] = (c >= 11 + o);
      if (c == 1 + o) begin
        check_eq({tag, "_addr"}, {9'd0, bus_if.out_a}, {9'd0, a});
        if (wr) check_eq({tag, "_wdata"}, {16'd0, bus_if.out_d}, {16'd0, d});
      end
      if (!wr && c == 11 + o) check_eq({tag, "_rdata"}, {16'd0, bus_if.rsp_data}, {16'd0, d});
      @(negedge mclk);
      if (c == 2 + o) bus_if.nor_d_in = d;
      if (c == 9 + o) bus_if.nor_d_in = 16'h0000;
    end
    check_eq({tag, "_own"}, own, e_own);
    check_eq({tag, "_drive"}, drv, e_drv);
    check_eq({tag, "_ddrive"}, dd, e_dd);
    check_eq({tag, "_ce"}, ce, e_ce);
    check_eq({tag, "_oe"}, oe, e_oe);
    check_eq({tag, "_we"}, we, e_we);
    check_eq({tag, "_rspv"}, rv, e_rv);
    check_eq({tag, "_ready"}, rdy, e_rdy);
  endtask

  initial begin
    int rst_cnt, rst_first, rst_last, drv_low, rv_cnt, rdy_cnt;
    logic [31:0] own, drv, rdy;
    n_checks = 0;
    n_errors = 0;
    reset_n          = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = 2'b00;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_wdata = '0;
    bus_if.nor_vcc   = 1'b1;
    bus_if.nor_d_in  = '0;
    repeat (3) @(negedge mclk);
    reset_n = 1'b1;
    @(negedge mclk);

    check_eq("rst_own", bus_if.bus_own, 1'b0);
    check_eq("rst_ctrl", {bus_if.bus_drive, bus_if.d_drive, bus_if.out_ce, bus_if.out_oe,
                          bus_if.out_we, bus_if.out_reset, bus_if.rsp_valid, bus_if.vcc_lost},
             32'd0);
    check_eq("rst_data", {bus_if.out_a, 9'd0} | {16'd0, bus_if.out_d | bus_if.rsp_data}, 32'd0);
    check_eq("rst_ready", bus_if.cmd_ready, 1'b1);

    run_access("rd_idle", 1'b0, 23'h012345, 16'hBEEF, 4);
    run_access("rd_owned", 1'b0, 23'h000ABC, 16'h5A5A, 0);
    run_access("wr_owned", 1'b1, 23'h7FFFFF, 16'hA55A, 0);

    // Reset pulse from OWNED.
    rst_cnt = 0; rst_first = 0; rst_last = 0; drv_low = 0;
    issue("rstp", 2'b10, 23'd0, 16'd0);
    for (int c = 1; c <= 251; c++) begin
      if (bus_if.out_reset) begin
        rst_cnt++;
        if (rst_first == 0) rst_first = c;
        rst_last = c;
      end
      if (!bus_if.bus_drive || !bus_if.bus_own) drv_low++;
      if (c == 251) check_eq("rstp_ready", bus_if.cmd_ready, 1'b1);
      @(negedge mclk);
    end
    check_eq("rstp_width", rst_cnt, 250);
    check_eq("rstp_first", rst_first, 1);
    check_eq("rstp_last", rst_last, 250);
    check_eq("rstp_drive", drv_low, 0);

    // Release from OWNED.
    own = '0; drv = '0; rdy = '0;
    issue("rel", 2'b11, 23'd0, 16'd0);
    for (int c = 1; c <= 6; c++) begin
      own[c] = bus_if.bus_own; drv[c] = bus_if.bus_drive; rdy[c] = bus_if.cmd_ready;
      @(negedge mclk);
    end
    check_eq("rel_drive", drv, 32'h0);
    check_eq("rel_own", own, 32'h1E);
    check_eq("rel_ready", rdy, 32'h60);

    run_access("rd_again", 1'b0, 23'h000001, 16'h1234, 4);

    // Power loss in the PULSE phase of a read from OWNED.
    issue("pwr", 2'b00, 23'h055555, 16'd0);
    repeat (3) @(negedge mclk);
    check_eq("pwr_inpulse", bus_if.out_oe, 1'b1);
    bus_if.nor_vcc = 1'b0;
    @(negedge mclk);
    check_eq("pwr_bus", {bus_if.bus_own, bus_if.bus_drive, bus_if.d_drive, bus_if.out_ce,
                         bus_if.out_oe, bus_if.out_we, bus_if.out_reset}, 32'd0);
    check_eq("pwr_addr", {9'd0, bus_if.out_a}, 32'd0);
    check_eq("pwr_lost", bus_if.vcc_lost, 1'b1);
    rv_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus_if.rsp_valid) rv_cnt++;
      if (bus_if.cmd_ready) rdy_cnt++;
      @(negedge mclk);
    end
    check_eq("pwr_norsp", rv_cnt, 0);
    check_eq("pwr_noready", rdy_cnt, 0);
    check_eq("pwr_lost_held", bus_if.vcc_lost, 1'b1);
    bus_if.nor_vcc = 1'b1;
    issue("pwr_rel", 2'b11, 23'd0, 16'd0);
    check_eq("pwr_cleared", bus_if.vcc_lost, 1'b0);
    check_eq("pwr_idle", bus_if.bus_own, 1'b0);

    // Asynchronous reset in the HOLD phase of a write from IDLE (HOLD = cycles 13..14).
    issue("arst", 2'b01, 23'h000055, 16'h0F0F);
    repeat (12) @(negedge mclk);
    check_eq("arst_hold", {bus_if.d_drive, bus_if.out_ce, bus_if.out_we}, 32'b110);
    reset_n = 1'b0;
    #1;
    check_eq("arst_bus", {bus_if.bus_own, bus_if.bus_drive, bus_if.d_drive, bus_if.out_ce},
             32'd0);
    check_eq("arst_data", {bus_if.out_a, 9'd0} | {16'd0, bus_if.out_d}, 32'd0);
    @(negedge mclk);
    reset_n = 1'b1;
    own = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge mclk);
      own[c] = bus_if.bus_own;
    end
    check_eq("arst_own", own, 32'd0);
    check_eq("arst_ready", bus_if.cmd_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/nor_bus_master.md
# nor_bus_master

Sequencer that takes ownership of the PS3 NOR bus from the console and executes single-word read, write and reset-pulse commands with programmable cycle timing. It sits beside the sniffer logic in the norflash top level. It drives the top level's tristate enables (trist, address/control drive, data drive) and the active-high out_* registers, which the top level inverts onto the pins. Commands come from the host-side command decoder; read data returns on a one-cycle response strobe.

## Interface
- SETTLE_CYC, 4, cycles between asserting bus_own and asserting bus_drive, and between dropping bus_drive and dropping bus_own.
- SETUP_CYC, 2, address/CE (and data) setup cycles before the strobe.
- PULSE_CYC, 6, OE/WE strobe width in cycles.
- HOLD_CYC, 2, cycles after the strobe before the bus is free.
- RESET_CYC, 250, out_reset pulse width in cycles.
- All timing parameters are in the range 1..65535. The internal counter is 16 bits.

Ports:
- mclk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_op  in  2  00 read, 01 write, 10 reset pulse, 11 release bus.
- cmd_addr  in  23  word address.
- cmd_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle strobe; read data valid.
- rsp_data  out  16  captured read word; holds its value until the next read.
- nor_vcc  in  1  console NOR power present.
- nor_d_in  in  16  sampled NOR data pins.
- bus_own  out  1  request trist (top level pulls nor_trist_n low).
- bus_drive  out  1  drive address/control pins.
- d_drive  out  1  drive data pins.
- out_a  out  23  address.
- out_d  out  16  write data.
- out_ce, out_oe, out_we, out_reset  out  1 each  active-high controls.
- vcc_lost  out  1  sticky flag: power dropped mid-operation.

## Operation
- States: IDLE, TAKEOVER, OWNED, SETUP, PULSE, HOLD, RSTP, RELEASE.
- cmd_ready = nor_vcc && (state==IDLE || state==OWNED). It is combinational.
- Accepting any command clears vcc_lost.
- IDLE:
  - accept read/write/reset → TAKEOVER.
  - accept release → no-op; stay IDLE.
- TAKEOVER: bus_own=1, bus_drive=0 for SETTLE_CYC cycles, then go to SETUP (read/write) or RSTP (reset).
- OWNED:
  - bus_own=1, bus_drive=1, all controls 0.
  - accept read/write → SETUP.
  - accept reset → RSTP.
  - accept release → RELEASE.
- SETUP: out_a=cmd_addr and out_ce=1, both latched at accept. For a write, out_d=cmd_wdata and d_drive=1.
- PULSE:
  - read: out_oe=1; nor_d_in is captured on the last PULSE cycle.
  - write: out_we=1.
- HOLD: out_oe=out_we=0. out_ce stays 1 and d_drive stays as in SETUP. Then → OWNED. out_ce and d_drive drop on entry to OWNED.
- RSTP: out_reset=1 for RESET_CYC cycles, then → OWNED.
- RELEASE: bus_drive=0 and d_drive=0 immediately; bus_own=1 for SETTLE_CYC cycles, then bus_own=0 → IDLE.
- Ordering: bus_own never rises in the same cycle as bus_drive, and never falls in the same cycle as bus_drive.
- Power loss: nor_vcc=0 in any state other than IDLE → next state IDLE with every output 0.
  - vcc_lost is set unless the state was OWNED or RELEASE.
  - An in-flight read produces no rsp_valid.
- out_a holds its last value in OWNED. It is cleared only by reset or power loss.

## Timing
- Reset values: every output register is 0 (rsp_data included); state IDLE. cmd_ready follows nor_vcc.
- Reset asserted mid-cycle forces IDLE and all outputs 0 asynchronously. The bus is released without the settle sequence.
- All outputs are registered except cmd_ready.
- Read from OWNED, accepted at cycle 0:
  - SETUP occupies cycles 1..S, PULSE S+1..S+P, HOLD S+P+1..S+P+H.
  - rsp_valid=1 in cycle S+P+H+1 (first OWNED cycle, defaults: cycle 11). cmd_ready is also high in that cycle.
- Write: same schedule with no rsp_valid.
- From IDLE, add SETTLE_CYC cycles (defaults: rsp at cycle 15).
- Back-to-back commands: a new command can be accepted in the first OWNED cycle. There are no bubbles beyond that.
- Release from OWNED at cycle 0: bus_drive=0 at cycle 1, bus_own=0 at cycle SETTLE_CYC+1.

## Test plan
- Read from IDLE with defaults, addr 0x12345, nor_d_in=0xBEEF during PULSE:
  - bus_own rises at cycle 1 and bus_drive at cycle 5.
  - out_oe is high for exactly 6 cycles.
  - rsp_valid/rsp_data=0xBEEF occur at cycle 15 only.
- Write addr 0x7FFFFF, data 0xA55A, from OWNED:
  - d_drive and out_d valid for cycles 1–10.
  - out_we high for cycles 3–8.
  - cmd_ready high again at cycle 11.
- Reset op from OWNED: out_reset high for exactly 250 cycles, then OWNED; bus_drive stays 1 throughout.
- Release: bus_drive falls at cycle 1 and bus_own at cycle 5. A read then reruns TAKEOVER.
- Drop nor_vcc during PULSE of a read:
  - next cycle all outputs are 0 and vcc_lost=1; no rsp_valid.
  - cmd_ready stays 0 until nor_vcc returns.
  - the next accepted command clears vcc_lost.
- Assert reset during HOLD of a write: all outputs go to 0 immediately; after reset release, state is IDLE and bus_own=0.
